// File: rtl/axis_insert_header_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
package axis_insert_header_pkg;

  // Widest beat (in bytes) the helper functions support; callers cast down.
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    STREAM,
    TAIL
  } state_t;

  // Keep mask with the top n bits of a width-bit field set (byte 0 is the MSB).
  function automatic logic [MAX_BYTES-1:0] msb_ones(input int unsigned n,
                                                    input int unsigned width);
    logic [MAX_BYTES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      mask[i] = (i < width) && (i + n >= width);
    end
    return mask;
  endfunction

  // Number of set bits in a keep mask.
  function automatic int unsigned popcount(input logic [MAX_BYTES-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      cnt = cnt + 32'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_byte_merge.sv
// Byte shifter: takes the upper word of {hold, data} shifted left by
// (DATA_BYTE_WD - shift_bytes) bytes and zeroes bytes whose keep bit is clear.
module axis_byte_merge #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_W        = 3
) (
  input  logic [DATA_WD-1:0]      hold,
  input  logic [DATA_WD-1:0]      data,
  input  logic [CNT_W-1:0]        shift_bytes,
  input  logic [DATA_BYTE_WD-1:0] keep,
  output logic [DATA_WD-1:0]      merged
);

  localparam int W2 = 2 * DATA_WD;

  logic [W2-1:0] combined;

  assign combined = {hold, data};

  // Output byte i comes from combined byte (i + DATA_BYTE_WD - shift_bytes).
  always_comb begin
    int src;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    src    = 0;
    merged = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      src = i + DATA_BYTE_WD - int'(shift_bytes);
      if (keep[DATA_BYTE_WD-1-i]) begin
        merged[DATA_WD-1-8*i -: 8] = combined[W2-1-8*src -: 8];
      end
    end
  end

endmodule

// File: rtl/axis_insert_header.sv
// Prepends the valid tail bytes of a side-channel header word to each packet
// and re-packs the stream into full beats with a left-aligned final keep.
module axis_insert_header
  import axis_insert_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [DATA_WD-1:0]       data_in,
  input  logic [DATA_BYTE_WD-1:0]  keep_in,
  input  logic                     last_in,
  output logic                     ready_in,
  output logic                     valid_out,
  output logic [DATA_WD-1:0]       data_out,
  output logic [DATA_BYTE_WD-1:0]  keep_out,
  output logic                     last_out,
  input  logic                     ready_out,
  input  logic                     valid_insert,
  input  logic [DATA_WD-1:0]       data_insert,
  input  logic [DATA_BYTE_WD-1:0]  keep_insert,
  input  logic [BYTE_CNT_WD:0]     byte_insert_cnt,
  output logic                     ready_insert
);

  localparam int CNT_W = BYTE_CNT_WD + 1;

  state_t                  state;
  logic [DATA_WD-1:0]      hold;
  logic [CNT_W-1:0]        hdr_cnt;
  logic [CNT_W-1:0]        tail_cnt;
  logic                    out_free;
  logic                    in_fire;
  logic                    hdr_fire;
  int unsigned             total_cnt;
  logic                    fits;
  logic [DATA_BYTE_WD-1:0] beat_keep;
  logic [DATA_BYTE_WD-1:0] tail_keep;
  logic [DATA_WD-1:0]      beat_data;
  logic [DATA_WD-1:0]      tail_data;
  logic                    keep_insert_unused;

  // The header length comes from byte_insert_cnt alone; keep_insert is advisory.
  assign keep_insert_unused = ^keep_insert;

  assign out_free     = !valid_out || ready_out;
  assign ready_insert = !rst && (state == IDLE);
  assign ready_in     = !rst && ((state == HDR) || (state == STREAM)) && out_free;
  assign hdr_fire     = valid_insert && ready_insert;
  assign in_fire      = valid_in && ready_in;

  // Byte accounting for the last beat and keep masks for the beat and tail.
  always_comb begin
    total_cnt = 32'(hdr_cnt) + popcount(MAX_BYTES'(keep_in));
    fits      = total_cnt <= DATA_BYTE_WD;
    if (last_in && fits) begin
      beat_keep = DATA_BYTE_WD'(msb_ones(total_cnt, DATA_BYTE_WD));
    end else begin
      beat_keep = '1;
    end
    tail_keep = DATA_BYTE_WD'(msb_ones(32'(tail_cnt), DATA_BYTE_WD));
  end

  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_W        (CNT_W)
  ) u_beat_merge (
    .hold        (hold),
    .data        (data_in),
    .shift_bytes (hdr_cnt),
    .keep        (beat_keep),
    .merged      (beat_data)
  );

  axis_byte_merge #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .CNT_W        (CNT_W)
  ) u_tail_merge (
    .hold        (hold),
    .data        ({DATA_WD{1'b0}}),
    .shift_bytes (hdr_cnt),
    .keep        (tail_keep),
    .merged      (tail_data)
  );

  // Packet FSM with registered output beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      hdr_cnt   <= '0;
      tail_cnt  <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (ready_out) begin
        valid_out <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (hdr_fire) begin
            hold    <= data_insert;
            hdr_cnt <= (byte_insert_cnt > CNT_W'(DATA_BYTE_WD)) ?
                       CNT_W'(DATA_BYTE_WD) : byte_insert_cnt;
            state   <= HDR;
          end
        end
        HDR, STREAM: begin
          if (in_fire) begin
            hold      <= data_in;
            valid_out <= 1'b1;
            data_out  <= beat_data;
            keep_out  <= beat_keep;
            if (last_in && fits) begin
              last_out <= 1'b1;
              state    <= IDLE;
            end else if (last_in) begin
              last_out <= 1'b0;
              tail_cnt <= CNT_W'(total_cnt - DATA_BYTE_WD);
              state    <= TAIL;
            end else begin
              last_out <= 1'b0;
              state    <= STREAM;
            end
          end
        end
        TAIL: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= tail_data;
            keep_out  <= tail_keep;
            last_out  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_insert_header.sv
// Directed self-checking bench for axis_insert_header (32-bit data path).
module tb_axis_insert_header;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic [2:0]  byte_insert_cnt;
  logic        ready_insert;

  int errors;
  int checks;
  int cycle;

  logic [31:0] q_data[$];
  logic [3:0]  q_keep[$];
  logic        q_last[$];
  int          q_cyc[$];

  axis_insert_header #(.DATA_WD(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .data_in         (data_in),
    .keep_in         (keep_in),
    .last_in         (last_in),
    .ready_in        (ready_in),
    .valid_out       (valid_out),
    .data_out        (data_out),
    .keep_out        (keep_out),
    .last_out        (last_out),
    .ready_out       (ready_out),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Record every output handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      q_data.push_back(data_out);
      q_keep.push_back(keep_out);
      q_last.push_back(last_out);
      q_cyc.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_header(input logic [31:0] d, input logic [2:0] cnt);
    int n;
    valid_insert    = 1'b1;
    data_insert     = d;
    byte_insert_cnt = cnt;
    keep_insert     = 4'((5'd1 << cnt) - 5'd1);
    n = 0;
    @(negedge clk);
    while (!ready_insert && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hdr_ready", 64'(ready_insert), 64'd1);
    @(posedge clk);
    #1;
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", 64'(ready_in), 64'd1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                             input logic l, output int cyc);
    cyc = -1;
    check({tag, "_present"}, 64'(q_data.size() > 0), 64'd1);
    if (q_data.size() > 0) begin
      check({tag, "_data"}, 64'(q_data.pop_front()), 64'(d));
      check({tag, "_keep"}, 64'(q_keep.pop_front()), 64'(k));
      check({tag, "_last"}, 64'(q_last.pop_front()), 64'(l));
      cyc = q_cyc.pop_front();
    end
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_extra_beats"}, 64'(q_data.size()), 64'd0);
  endtask

  task automatic clear_queues();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_cyc.delete();
  endtask

  initial begin
    int c0, c1, c2;
    errors          = 0;
    checks          = 0;
    cycle           = 0;
    rst             = 1'b1;
    valid_in        = 1'b0;
    data_in         = '0;
    keep_in         = '0;
    last_in         = 1'b0;
    ready_out       = 1'b1;
    valid_insert    = 1'b0;
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_keep_out", 64'(keep_out), 64'd0);
    check("rst_last_out", 64'(last_out), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    check("rst_ready_insert", 64'(ready_insert), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_insert", 64'(ready_insert), 64'd1);
    check("idle_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;

    // H=2, result fits in the last beat
    send_header(32'hAABBCCDD, 3'd2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    drain();
    expect_beat("h2_b0", 32'hCCDD1122, 4'hF, 1'b0, c0);
    expect_beat("h2_b1", 32'h33445566, 4'hF, 1'b1, c1);
    expect_empty("h2");

    // H=3, overflow produces a tail beat
    send_header(32'h00AABBCC, 3'd3);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'b1110, 1'b1);
    drain();
    expect_beat("h3_b0", 32'hAABBCC11, 4'hF, 1'b0, c0);
    expect_beat("h3_b1", 32'h22334455, 4'hF, 1'b0, c1);
    expect_beat("h3_tail", 32'h66770000, 4'b1100, 1'b1, c2);
    check("h3_tail_follows", 64'(c2 - c1), 64'd1);
    expect_empty("h3");

    // H=4, header is a full beat; single-beat packet
    send_header(32'hDEADBEEF, 3'd4);
    send_beat(32'h11223344, 4'b1000, 1'b1);
    drain();
    expect_beat("h4_b0", 32'hDEADBEEF, 4'hF, 1'b0, c0);
    expect_beat("h4_tail", 32'h11000000, 4'b1000, 1'b1, c1);
    expect_empty("h4");

    // One-cycle valid_in gap gives exactly one output bubble
    send_header(32'h01020304, 3'd2);
    send_beat(32'hA1A2A3A4, 4'hF, 1'b0);
    @(posedge clk);
    #1;
    send_beat(32'hB1B2B3B4, 4'hF, 1'b0);
    send_beat(32'hC1C2C3C4, 4'b1000, 1'b1);
    drain();
    expect_beat("gap_b0", 32'h0304A1A2, 4'hF, 1'b0, c0);
    expect_beat("gap_b1", 32'hA3A4B1B2, 4'hF, 1'b0, c1);
    expect_beat("gap_b2", 32'hB3B4C100, 4'b1110, 1'b1, c2);
    check("gap_bubble", 64'(c1 - c0), 64'd2);
    check("gap_no_bubble", 64'(c2 - c1), 64'd1);
    expect_empty("gap");

    // Backpressure: ready_out low for 3 cycles mid-packet
    send_header(32'h000000EE, 3'd1);
    send_beat(32'h10111213, 4'hF, 1'b0);
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'h20212223;
    keep_in   = 4'hF;
    last_in   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready_in", 64'(ready_in), 64'd0);
      check("stall_valid_out", 64'(valid_out), 64'd1);
      check("stall_data_out", 64'(data_out), 64'hEE101112);
      check("stall_keep_last", 64'({keep_out, last_out}), 64'({4'hF, 1'b0}));
    end
    @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(32'h20212223, 4'hF, 1'b0);
    send_beat(32'h30313233, 4'hF, 1'b1);
    drain();
    expect_beat("bp_b0", 32'hEE101112, 4'hF, 1'b0, c0);
    expect_beat("bp_b1", 32'h13202122, 4'hF, 1'b0, c1);
    expect_beat("bp_b2", 32'h23303132, 4'hF, 1'b0, c2);
    expect_beat("bp_tail", 32'h33000000, 4'b1000, 1'b1, c2);
    expect_empty("bp");

    // Reset mid-packet, then a pass-through (H=0) packet
    send_header(32'hAABBCCDD, 3'd2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_ready_insert", 64'(ready_insert), 64'd0);
    check("midrst_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_ready_insert", 64'(ready_insert), 64'd1);
    @(posedge clk);
    #1;
    clear_queues();
    send_header(32'h99887766, 3'd0);
    send_beat(32'hCAFEF00D, 4'hF, 1'b0);
    send_beat(32'h12345678, 4'b1100, 1'b1);
    drain();
    expect_beat("h0_b0", 32'hCAFEF00D, 4'hF, 1'b0, c0);
    expect_beat("h0_b1", 32'h12340000, 4'b1100, 1'b1, c1);
    expect_empty("h0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
